ecc_apb_sequencer: RTL and testbench

ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

---
 rtl/ecc_apb_sequencer_pkg.sv | 47 ++++
 rtl/ecc_apb_sequencer_apb_write_phy.sv | 60 ++++++
 rtl/ecc_apb_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ecc_apb_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_apb_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ecc_apb_sequencer_pkg
// Shared definitions for the ECC APB sequencer:
//   - state_t            : sequencer FSM states
//   - ADDR_*             : ECC core register map (byte addresses)
//   - CMD_* / WIDTH_*    : encodings carried by job_cmd and job_width
//   - reg_addr()         : write index -> register address
// ---------------------------------------------------------------------------
package ecc_apb_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT_DONE,
    RESP
  } state_t;

  // ECC core register map
  localparam logic [3:0] ADDR_CTRL           = 4'd0;
  localparam logic [3:0] ADDR_DATA_IN        = 4'd4;
  localparam logic [3:0] ADDR_CODEWORD_WIDTH = 4'd8;
  localparam logic [3:0] ADDR_NOISE          = 4'd12;

  // job_cmd encodings (written to CTRL)
  localparam logic [1:0] CMD_ENCODE = 2'd0;
  localparam logic [1:0] CMD_DECODE = 2'd1;
  localparam logic [1:0] CMD_FULL   = 2'd2;

  // job_width encodings (written to CODEWORD_WIDTH)
  localparam logic [1:0] WIDTH_8  = 2'd0;
  localparam logic [1:0] WIDTH_16 = 2'd1;
  localparam logic [1:0] WIDTH_32 = 2'd2;

  // CTRL is written last so the core starts only once its operands are loaded
  localparam logic [1:0] LAST_INDEX = 2'd3;

  function automatic logic [3:0] reg_addr(input logic [1:0] index);
    case (index)
      2'd0:    return ADDR_DATA_IN;
      2'd1:    return ADDR_CODEWORD_WIDTH;
      2'd2:    return ADDR_NOISE;
      default: return ADDR_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_sequencer_apb_write_phy.sv
// ---------------------------------------------------------------------------
// apb_write_phy
// Two-phase APB write master. A one-cycle start pulse loads addr/wdata and
// puts the bus in SETUP on the next edge; ACCESS follows for one cycle, and
// done is high during ACCESS. If start is asserted during ACCESS the next
// SETUP follows back to back; otherwise the bus returns to all-zero.
// Ports:
//   clk, arstn            clock, asynchronous active-low reset
//   start, addr, wdata    transfer request (sampled on the start cycle)
//   done                  high during the ACCESS cycle
//   psel, penable, pwrite, paddr, pwdata   registered APB master outputs
// ---------------------------------------------------------------------------
module apb_write_phy #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else if (start) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      pwrite  <= 1'b1;
      paddr   <= addr;
      pwdata  <= wdata;
    end else if (psel && !penable) begin
      // SETUP -> ACCESS, address and data held
      penable <= 1'b1;
    end else begin
      // Idle bus drives zero on every field
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end
  end

  assign done = psel && penable;

endmodule

// File: rtl/ecc_apb_sequencer.sv
// ---------------------------------------------------------------------------
// ecc_apb_sequencer
// Accepts one ECC job at a time, programs the ECC core over APB (DATA_IN,
// CODEWORD_WIDTH, NOISE, then CTRL), waits for operation_done with a bounded
// timeout, and presents the result on a valid/ready port.
// Ports:
//   clk, arstn                    clock, asynchronous active-low reset
//   job_*                         job request (valid/ready handshake)
//   PSEL..PWDATA                  APB master write port
//   operation_done, data_out,
//   num_of_errors                 ECC core status
//   res_*                         result (valid/ready handshake)
// ---------------------------------------------------------------------------
module ecc_apb_sequencer
  import ecc_apb_sequencer_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT         = 64
) (
  input  logic                       clk,
  input  logic                       arstn,
  // job port
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [DATA_WIDTH-1:0]      job_data,
  input  logic [1:0]                 job_cmd,
  input  logic [1:0]                 job_width,
  input  logic [DATA_WIDTH-1:0]      job_noise,
  // APB master
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  // ECC core status
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  // result port
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_errors,
  output logic                       res_timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                      state;
  logic [1:0]                  index;
  logic [CNT_W-1:0]            wait_cnt;

  logic [DATA_WIDTH-1:0]       data_q;
  logic [DATA_WIDTH-1:0]       noise_q;
  logic [1:0]                  cmd_q;
  logic [1:0]                  width_q;

  logic                        accept;
  logic                        phy_start;
  logic                        phy_done;
  logic [1:0]                  start_index;
  logic [DATA_WIDTH-1:0]       cur_data;
  logic [DATA_WIDTH-1:0]       cur_noise;
  logic [1:0]                  cur_cmd;
  logic [1:0]                  cur_width;
  logic [AMBA_ADDR_WIDTH-1:0]  start_addr;
  logic [AMBA_WORD-1:0]        start_wdata;

  assign accept = (state == IDLE) && job_valid && job_ready;

  // The first write is launched in the handshake cycle, before the job
  // registers are loaded, so operands come straight from the job port then.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    phy_start   = 1'b0;
    start_index = 2'd0;
    start_wdata = '0;
    cur_data    = accept ? job_data  : data_q;
    cur_noise   = accept ? job_noise : noise_q;
    cur_cmd     = accept ? job_cmd   : cmd_q;
    cur_width   = accept ? job_width : width_q;

    if (accept) begin
      phy_start   = 1'b1;
      start_index = 2'd0;
    end else if (state == ACCESS && phy_done && index != LAST_INDEX) begin
      phy_start   = 1'b1;
      start_index = index + 2'd1;
    end

    start_addr = AMBA_ADDR_WIDTH'(reg_addr(start_index));
    case (start_index)
      2'd0:    start_wdata = AMBA_WORD'(cur_data);
      2'd1:    start_wdata = AMBA_WORD'(cur_width);
      2'd2:    start_wdata = AMBA_WORD'(cur_noise);
      default: start_wdata = AMBA_WORD'(cur_cmd);
    endcase
  end

  apb_write_phy #(
    .ADDR_W (AMBA_ADDR_WIDTH),
    .DATA_W (AMBA_WORD)
  ) u_phy (
    .clk     (clk),
    .arstn   (arstn),
    .start   (phy_start),
    .addr    (start_addr),
    .wdata   (start_wdata),
    .done    (phy_done),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .paddr   (PADDR),
    .pwdata  (PWDATA)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= IDLE;
      index       <= 2'd0;
      wait_cnt    <= '0;
      data_q      <= '0;
      noise_q     <= '0;
      cmd_q       <= 2'd0;
      width_q     <= 2'd0;
      job_ready   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_errors  <= 2'd0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // job_ready rises on the first edge after reset release
          job_ready <= 1'b1;
          if (accept) begin
            data_q    <= job_data;
            noise_q   <= job_noise;
            cmd_q     <= job_cmd;
            width_q   <= job_width;
            index     <= 2'd0;
            job_ready <= 1'b0;
            state     <= SETUP;
          end
        end

        SETUP: state <= ACCESS;

        ACCESS: begin
          if (phy_done) begin
            if (index == LAST_INDEX) begin
              wait_cnt <= '0;
              state    <= WAIT_DONE;
            end else begin
              index <= index + 2'd1;
              state <= SETUP;
            end
          end
        end

        WAIT_DONE: begin
          if (operation_done) begin
            res_data    <= data_out;
            res_errors  <= num_of_errors;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            res_data    <= '0;
            res_errors  <= 2'd0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= RESP;
          end else if (wait_cnt != '1) begin
            // Saturating count: never wraps back to zero
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ecc_apb_sequencer
// Directed bench for ecc_apb_sequencer with default parameters. The bench
// plays the ECC core: it watches the APB writes and drives operation_done,
// data_out and num_of_errors by hand. Inputs are driven and outputs sampled
// 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ecc_apb_sequencer;

  logic        clk;
  logic        arstn;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_data;
  logic [1:0]  job_cmd;
  logic [1:0]  job_width;
  logic [31:0] job_noise;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [19:0] paddr;
  logic [31:0] pwdata;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_errors;
  logic        res_timeout;

  int errors = 0;
  int checks = 0;

  // Captured APB writes of the current job
  logic [19:0] wr_addr [4];
  logic [31:0] wr_data [4];
  int          proto_bad;

  ecc_apb_sequencer dut (
    .clk            (clk),
    .arstn          (arstn),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_data       (job_data),
    .job_cmd        (job_cmd),
    .job_width      (job_width),
    .job_noise      (job_noise),
    .PSEL           (psel),
    .PENABLE        (penable),
    .PWRITE         (pwrite),
    .PADDR          (paddr),
    .PWDATA         (pwdata),
    .operation_done (operation_done),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_errors     (res_errors),
    .res_timeout    (res_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no comparisons) ----------------

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a job for one cycle; returns just after the handshake edge.
  task automatic issue_job(input logic [31:0] d, input logic [1:0] c,
                           input logic [1:0] w, input logic [31:0] n);
    job_data  = d;
    job_cmd   = c;
    job_width = w;
    job_noise = n;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    job_data  = '0;
    job_cmd   = '0;
    job_width = '0;
    job_noise = '0;
  endtask

  // Walks the 8 APB cycles, recording each write and counting phase
  // violations. A bogus operation_done pulse is injected in the SETUP phase
  // of write pulse_write (-1: none). Returns in the first WAIT_DONE cycle.
  task automatic capture_writes(input int pulse_write);
    proto_bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == pulse_write) begin
        operation_done = 1'b1;
        data_out       = 32'hDEAD_BEEF;
        num_of_errors  = 2'd3;
      end
      if (!(psel === 1'b1 && penable === 1'b0 && pwrite === 1'b1)) proto_bad++;
      wr_addr[k] = paddr;
      wr_data[k] = pwdata;
      step();
      operation_done = 1'b0;
      data_out       = '0;
      num_of_errors  = '0;
      if (!(psel === 1'b1 && penable === 1'b1 && pwrite === 1'b1 &&
            paddr === wr_addr[k] && pwdata === wr_data[k])) proto_bad++;
      step();
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------

  task automatic test_reset();
    arstn = 1'b0;
    step();
    step();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, res_valid, res_data, res_errors, res_timeout, job_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h res_valid=%b res_data=%h res_errors=%0d res_timeout=%b job_ready=%b, all required 0",
               psel, penable, pwrite, paddr, pwdata, res_valid, res_data, res_errors, res_timeout, job_ready);
    end
    arstn = 1'b1;
    #1;
    checks++;
    if (job_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_before_edge: job_ready=%b required 0", job_ready);
    end
    step();
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_first_edge: job_ready=%b required 1", job_ready);
    end
  endtask

  task automatic test_encode();
    logic [19:0] exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{20'd4, 20'd8, 20'd12, 20'd0};
    exp_d = '{32'h0000_00A5, 32'd0, 32'd0, 32'd0};
    issue_job(32'h0000_00A5, 2'd0, 2'd0, 32'd0);
    checks++;
    if (job_ready !== 1'b0) begin
      errors++;
      $display("FAIL encode_job_ready_busy: job_ready=%b required 0", job_ready);
    end
    capture_writes(-1);
    checks++;
    if (proto_bad !== 0) begin
      errors++;
      $display("FAIL encode_apb_phases: violations=%0d required 0", proto_bad);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_addr[k] !== exp_a[k] || wr_data[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL encode_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                 k, wr_addr[k], wr_data[k], exp_a[k], exp_d[k]);
      end
    end
    // First WAIT_DONE cycle: bus idle, no result yet
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== '0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL encode_wait_idle: psel=%b penable=%b paddr=%h pwdata=%h res_valid=%b required all 0",
               psel, penable, paddr, pwdata, res_valid);
    end
    operation_done = 1'b1;
    data_out       = 32'h1234_00A5;
    num_of_errors  = 2'd1;
    step();
    operation_done = 1'b0;
    data_out       = '0;
    num_of_errors  = '0;
    // res_valid on the 10th edge counting the handshake edge
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h1234_00A5 || res_errors !== 2'd1 || res_timeout !== 1'b0) begin
      errors++;
      $display("FAIL encode_result: valid=%b data=%h errors=%0d timeout=%b required 1 123400a5 1 0",
               res_valid, res_data, res_errors, res_timeout);
    end
    release_result();
  endtask

  task automatic test_decode();
    logic [19:0] exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{20'd4, 20'd8, 20'd12, 20'd0};
    exp_d = '{32'h0000_1234, 32'd2, 32'd3, 32'd1};
    issue_job(32'h0000_1234, 2'd1, 2'd2, 32'h0000_0003);
    capture_writes(-1);
    checks++;
    if (proto_bad !== 0) begin
      errors++;
      $display("FAIL decode_apb_phases: violations=%0d required 0", proto_bad);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_addr[k] !== exp_a[k] || wr_data[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL decode_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                 k, wr_addr[k], wr_data[k], exp_a[k], exp_d[k]);
      end
    end
    // Core takes a few cycles before reporting
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_early_valid: res_valid=%b required 0", res_valid);
    end
    operation_done = 1'b1;
    data_out       = 32'h0000_1230;
    num_of_errors  = 2'd2;
    step();
    operation_done = 1'b0;
    data_out       = '0;
    num_of_errors  = '0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0000_1230 || res_errors !== 2'd2 || res_timeout !== 1'b0) begin
      errors++;
      $display("FAIL decode_result: valid=%b data=%h errors=%0d timeout=%b required 1 00001230 2 0",
               res_valid, res_data, res_errors, res_timeout);
    end
    release_result();
  endtask

  task automatic test_timeout();
    int n;
    int bus_bad;
    issue_job(32'h0000_003C, 2'd0, 2'd0, 32'd0);
    capture_writes(-1);
    // Status lines busy but operation_done never rises
    data_out      = 32'hFFFF_FFFF;
    num_of_errors = 2'd3;
    n       = 0;
    bus_bad = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      if ({psel, penable, pwrite, paddr, pwdata} !== '0) bus_bad++;
      step();
      n++;
    end
    data_out      = '0;
    num_of_errors = '0;
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL timeout_cycles: res_valid after %0d cycles past CTRL access, required 64", n);
    end
    checks++;
    if (bus_bad !== 0) begin
      errors++;
      $display("FAIL timeout_bus_idle: %0d cycles with non-zero APB outputs, required 0", bus_bad);
    end
    checks++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_data !== 32'd0 || res_errors !== 2'd0) begin
      errors++;
      $display("FAIL timeout_result: valid=%b timeout=%b data=%h errors=%0d required 1 1 0 0",
               res_valid, res_timeout, res_data, res_errors);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int unstable;
    issue_job(32'h0000_BEEF, 2'd2, 2'd1, 32'h0000_0101);
    capture_writes(-1);
    operation_done = 1'b1;
    data_out       = 32'h0000_CAFE;
    num_of_errors  = 2'd1;
    step();
    operation_done = 1'b0;
    data_out       = 32'h5555_5555;
    num_of_errors  = 2'd3;
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_data !== 32'h0000_CAFE || res_errors !== 2'd1 ||
          res_timeout !== 1'b0 || job_ready !== 1'b0) unstable++;
      step();
    end
    data_out      = '0;
    num_of_errors = '0;
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d of 5 stalled cycles changed result or raised job_ready, required 0", unstable);
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (job_ready !== 1'b0 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ready_cycle: job_ready=%b res_valid=%b required 0 1", job_ready, res_valid);
    end
    step();
    res_ready = 1'b0;
    checks++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_after_ready: job_ready=%b res_valid=%b required 1 0", job_ready, res_valid);
    end
  endtask

  task automatic test_reset_abort();
    int seen_valid;
    issue_job(32'h0000_0099, 2'd1, 2'd2, 32'h0000_0011);
    // SETUP0, ACCESS0, SETUP1, ACCESS1, SETUP2 -> now in ACCESS2
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 20'd12 || pwdata !== 32'h0000_0011) begin
      errors++;
      $display("FAIL abort_in_access2: psel=%b penable=%b paddr=%0d pwdata=%h required 1 1 12 00000011",
               psel, penable, paddr, pwdata);
    end
    #2;
    arstn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, res_valid, job_ready} !== '0) begin
      errors++;
      $display("FAIL abort_outputs_cleared: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h res_valid=%b job_ready=%b required all 0",
               psel, penable, pwrite, paddr, pwdata, res_valid, job_ready);
    end
    step();
    arstn = 1'b1;
    step();
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready_after_release: job_ready=%b required 1", job_ready);
    end
    // Stray done pulses while idle must not create a result
    operation_done = 1'b1;
    data_out       = 32'h0BAD_0BAD;
    seen_valid     = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid !== 1'b0 || psel !== 1'b0) seen_valid++;
      step();
    end
    operation_done = 1'b0;
    data_out       = '0;
    checks++;
    if (seen_valid !== 0) begin
      errors++;
      $display("FAIL abort_no_result: %0d cycles with res_valid or PSEL set, required 0", seen_valid);
    end
    // Fresh job runs normally
    issue_job(32'h0000_0077, 2'd0, 2'd0, 32'd0);
    capture_writes(-1);
    checks++;
    if (proto_bad !== 0 || wr_addr[0] !== 20'd4 || wr_data[0] !== 32'h0000_0077 || wr_addr[3] !== 20'd0) begin
      errors++;
      $display("FAIL abort_next_job_writes: violations=%0d w0=(%0d,%h) w3 addr=%0d required 0 (4,00000077) 0",
               proto_bad, wr_addr[0], wr_data[0], wr_addr[3]);
    end
    operation_done = 1'b1;
    data_out       = 32'h0000_0770;
    num_of_errors  = 2'd0;
    step();
    operation_done = 1'b0;
    data_out       = '0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0000_0770 || res_timeout !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_job_result: valid=%b data=%h timeout=%b required 1 00000770 0",
               res_valid, res_data, res_timeout);
    end
    release_result();
  endtask

  task automatic test_done_in_setup();
    issue_job(32'h0000_5A00, 2'd2, 2'd1, 32'h0000_0040);
    // Bogus pulse during the CTRL SETUP cycle
    capture_writes(3);
    checks++;
    if (proto_bad !== 0 || wr_addr[3] !== 20'd0 || wr_data[3] !== 32'd2) begin
      errors++;
      $display("FAIL setup_pulse_writes: violations=%0d ctrl=(%0d,%h) required 0 (0,00000002)",
               proto_bad, wr_addr[3], wr_data[3]);
    end
    step();
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL setup_pulse_ignored: res_valid=%b required 0", res_valid);
    end
    operation_done = 1'b1;
    data_out       = 32'h0000_5A5A;
    num_of_errors  = 2'd1;
    step();
    operation_done = 1'b0;
    data_out       = '0;
    num_of_errors  = '0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0000_5A5A || res_errors !== 2'd1 || res_timeout !== 1'b0) begin
      errors++;
      $display("FAIL setup_pulse_result: valid=%b data=%h errors=%0d timeout=%b required 1 00005a5a 1 0",
               res_valid, res_data, res_errors, res_timeout);
    end
    release_result();
  endtask

  initial begin
    arstn          = 1'b0;
    job_valid      = 1'b0;
    job_data       = '0;
    job_cmd        = '0;
    job_width      = '0;
    job_noise      = '0;
    operation_done = 1'b0;
    data_out       = '0;
    num_of_errors  = '0;
    res_ready      = 1'b0;

    test_reset();
    test_encode();
    test_decode();
    test_timeout();
    test_backpressure();
    test_reset_abort();
    test_done_in_setup();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
